// File: rtl/simon_pkg.sv
// Shared Simon 32/64 constants and word-level helpers.
// Both the encryption rounds and the decrypt core use these.
package simon_pkg;

  localparam int ROUNDS    = 32;
  localparam int KEY_WORDS = 4;

  localparam logic [15:0] SIMON_C  = 16'hFFFC;
  // Bit i of the z0 sequence is SIMON_Z0[61-i] (index 0 is the leftmost bit).
  localparam logic [61:0] SIMON_Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_DECRYPT
  } state_e;

  function automatic logic [15:0] rol16(input logic [15:0] v, input int unsigned n);
    return (v << n) | (v >> (16 - n));
  endfunction

  function automatic logic [15:0] ror16(input logic [15:0] v, input int unsigned n);
    return (v >> n) | (v << (16 - n));
  endfunction

  function automatic logic [15:0] simon_f(input logic [15:0] v);
    return (rol16(v, 1) & rol16(v, 8)) ^ rol16(v, 2);
  endfunction

endpackage

// File: rtl/simon_decrypt_core_if.sv
// Start/busy/done request bundle for the Simon decrypt core.
// The master drives key/ciphertext and start; the slave returns status and plaintext.
interface simon_decrypt_core_if;
  logic        start;
  logic [63:0] key;
  logic [15:0] u_cphrtxt;
  logic [15:0] l_cphrtxt;
  logic        busy;
  logic        done;
  logic [15:0] u_plntxt;
  logic [15:0] l_plntxt;

  modport master (
    output start, key, u_cphrtxt, l_cphrtxt,
    input  busy, done, u_plntxt, l_plntxt
  );

  modport slave (
    input  start, key, u_cphrtxt, l_cphrtxt,
    output busy, done, u_plntxt, l_plntxt
  );
endinterface

// File: rtl/simon_key_step.sv
// One Simon 32/64 key-schedule step (m=4): k[i+4] from k[i], k[i+1], k[i+3] and z0[i].
// Purely combinational.
module simon_key_step
  import simon_pkg::*;
(
  input  logic [15:0] ki_i,
  input  logic [15:0] ki1_i,
  input  logic [15:0] ki3_i,
  input  logic        z_i,
  output logic [15:0] ki4_o
);

  logic [15:0] tmp;

  assign tmp   = ror16(ki3_i, 3) ^ ki1_i;
  assign ki4_o = SIMON_C ^ {15'd0, z_i} ^ ki_i ^ tmp ^ ror16(tmp, 1);

endmodule

// File: rtl/simon_decrypt_core.sv
// Iterative Simon 32/64 decryption: 28 key-expansion cycles then 32 inverse rounds.
// done pulses 60 edges after the start-sampling edge; start is ignored while busy.
module simon_decrypt_core
  import simon_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  simon_decrypt_core_if.slave  bus
);

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [15:0] x_q, y_q;
  logic [15:0] u_q, l_q;
  logic        busy_q, done_q;
  logic [15:0] ks_q [ROUNDS];

  logic [4:0]  kidx;
  logic [5:0]  zidx;
  logic [15:0] ks_d;
  logic [15:0] x_d, y_d;

  // kidx = i while expanding; zidx stays within 30..61 for every cnt value.
  assign kidx = cnt_q - 5'd4;
  assign zidx = 6'd61 - {1'b0, kidx};

  simon_key_step u_key_step (
    .ki_i  (ks_q[kidx]),
    .ki1_i (ks_q[kidx + 5'd1]),
    .ki3_i (ks_q[cnt_q - 5'd1]),
    .z_i   (SIMON_Z0[zidx]),
    .ki4_o (ks_d)
  );

  assign x_d = y_q;
  assign y_d = x_q ^ simon_f(y_q) ^ ks_q[cnt_q];

  // Key storage carries no reset: every entry is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && bus.start) begin
      ks_q[0] <= bus.key[15:0];
      ks_q[1] <= bus.key[31:16];
      ks_q[2] <= bus.key[47:32];
      ks_q[3] <= bus.key[63:48];
    end else if (state_q == ST_EXPAND) begin
      ks_q[cnt_q] <= ks_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
      x_q     <= 16'd0;
      y_q     <= 16'd0;
      u_q     <= 16'd0;
      l_q     <= 16'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            x_q     <= bus.u_cphrtxt;
            y_q     <= bus.l_cphrtxt;
            cnt_q   <= 5'(KEY_WORDS);
            busy_q  <= 1'b1;
            state_q <= ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          if (cnt_q == 5'(ROUNDS - 1)) begin
            state_q <= ST_DECRYPT;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        ST_DECRYPT: begin
          x_q <= x_d;
          y_q <= y_d;
          if (cnt_q == 5'd0) begin
            u_q     <= x_d;
            l_q     <= y_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.u_plntxt = u_q;
  assign bus.l_plntxt = l_q;

endmodule

// File: tb/tb_simon_decrypt_core.sv
// Directed and random bench for simon_decrypt_core; a queue holds the expected
// plaintext of every accepted start and is drained whenever done pulses.
module tb_simon_decrypt_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  logic [31:0] sb [$];
  logic [15:0] mks [32];
  logic [32:0] mon_exp;

  localparam logic [63:0] STD_KEY = 64'h1918_1110_0908_0100;
  localparam logic [15:0] STD_CU  = 16'hC69B;
  localparam logic [15:0] STD_CL  = 16'hE9BB;
  localparam logic [31:0] STD_PT  = 32'h6565_6877;

  simon_decrypt_core_if bus_if ();

  simon_decrypt_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rl(input logic [15:0] v, input int n);
    return (v << n) | (v >> (16 - n));
  endfunction

  function automatic logic [15:0] rr(input logic [15:0] v, input int n);
    return (v >> n) | (v << (16 - n));
  endfunction

  function automatic logic [15:0] fm(input logic [15:0] v);
    return (rl(v, 1) & rl(v, 8)) ^ rl(v, 2);
  endfunction

  // Reference schedule in the published form: ~k[i] ^ tmp ^ ROR1(tmp) ^ z ^ 3.
  function automatic void expand(input logic [63:0] k);
    logic [61:0] zc;
    logic [15:0] tmp;
    zc = 62'b11111010001001010110000111001101111101000100101011000011100110;
    for (int i = 0; i < 4; i++) mks[i] = k[16*i +: 16];
    for (int i = 0; i < 28; i++) begin
      tmp = rr(mks[i+3], 3) ^ mks[i+1];
      tmp = tmp ^ rr(tmp, 1);
      mks[i+4] = ~mks[i] ^ tmp ^ {15'd0, zc[61-i]} ^ 16'd3;
    end
  endfunction

  function automatic logic [31:0] encrypt(input logic [63:0] k, input logic [31:0] pt);
    logic [15:0] x, y, t;
    expand(k);
    x = pt[31:16];
    y = pt[15:0];
    for (int i = 0; i < 32; i++) begin
      t = x;
      x = y ^ fm(x) ^ mks[i];
      y = t;
    end
    return {x, y};
  endfunction

  function automatic logic [31:0] decrypt(input logic [63:0] k, input logic [31:0] ct);
    logic [15:0] x, y, t;
    expand(k);
    x = ct[31:16];
    y = ct[15:0];
    for (int i = 31; i >= 0; i--) begin
      t = y;
      y = x ^ fm(y) ^ mks[i];
      x = t;
    end
    return {x, y};
  endfunction

  always @(negedge clk) begin
    if (bus_if.done === 1'b1) begin
      done_cnt++;
      if (sb.size() > 0) mon_exp = {1'b1, sb.pop_front()};
      else mon_exp = 33'd0;
      check("done_result", {31'd0, bus_if.done, bus_if.u_plntxt, bus_if.l_plntxt}, {31'd0, mon_exp});
    end
  end

  // Called just after a posedge while the DUT is idle; returns the count at the sampling edge.
  task automatic issue(input logic [63:0] k, input logic [15:0] cu, input logic [15:0] cl,
                       input logic [31:0] exp, output int t0);
    bus_if.key       = k;
    bus_if.u_cphrtxt = cu;
    bus_if.l_cphrtxt = cl;
    bus_if.start     = 1'b1;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input string tag, input int t0, output int nbusy);
    int lat;
    lat = -1;
    nbusy = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus_if.done === 1'b1) begin
        lat = cyc - t0;
        break;
      end
      if (bus_if.busy === 1'b1) nbusy++;
    end
    check({tag, "_latency"}, lat, 60);
  endtask

  initial begin
    int t0, t1, nb, dc0;
    logic [63:0] rk;
    logic [31:0] rpt, rct;

    bus_if.start = 1'b0;
    bus_if.key = 64'd0;
    bus_if.u_cphrtxt = 16'd0;
    bus_if.l_cphrtxt = 16'd0;

    #3;
    check("rst_busy", bus_if.busy, 0);
    check("rst_done", bus_if.done, 0);
    check("rst_u", bus_if.u_plntxt, 0);
    check("rst_l", bus_if.l_plntxt, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Standard vector: latency and busy width.
    issue(STD_KEY, STD_CU, STD_CL, STD_PT, t0);
    check("std_busy_after_start", bus_if.busy, 1);
    wait_done("std", t0, nb);
    check("std_busy_cycles", nb, 60);
    check("std_busy_at_done", bus_if.busy, 0);
    check("std_pt", {bus_if.u_plntxt, bus_if.l_plntxt}, STD_PT);
    @(posedge clk);
    #1;

    // Start while busy is ignored; schedule probed after expansion.
    dc0 = done_cnt;
    issue(STD_KEY, STD_CU, STD_CL, STD_PT, t0);
    repeat (9) @(posedge clk);
    #1;
    bus_if.key = 64'hDEAD_BEEF_0123_4567;
    bus_if.u_cphrtxt = 16'h1234;
    bus_if.l_cphrtxt = 16'h5678;
    bus_if.start = 1'b1;
    @(posedge clk);
    #1 bus_if.start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    expand(STD_KEY);
    for (int i = 0; i < 32; i++) check($sformatf("ks%0d", i), dut.ks_q[i], mks[i]);
    wait_done("ignored_start", t0, nb);
    check("ignored_start_pt", {bus_if.u_plntxt, bus_if.l_plntxt}, STD_PT);
    repeat (70) @(posedge clk);
    #1;
    check("ignored_start_dones", done_cnt - dc0, 1);
    check("hold_pt", {bus_if.u_plntxt, bus_if.l_plntxt}, STD_PT);

    // Back-to-back: start held through the done cycle.
    bus_if.key = STD_KEY;
    bus_if.u_cphrtxt = STD_CU;
    bus_if.l_cphrtxt = STD_CL;
    bus_if.start = 1'b1;
    sb.push_back(STD_PT);
    @(posedge clk);
    #1;
    t0 = cyc;
    bus_if.key = 64'd0;
    bus_if.u_cphrtxt = 16'd0;
    bus_if.l_cphrtxt = 16'd0;
    sb.push_back(decrypt(64'd0, 32'd0));
    wait_done("b2b_first", t0, nb);
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    t1 = cyc;
    check("b2b_restart_busy", bus_if.busy, 1);
    check("b2b_first_pt_held", {bus_if.u_plntxt, bus_if.l_plntxt}, STD_PT);
    wait_done("b2b_second", t1, nb);
    check("b2b_second_pt", {bus_if.u_plntxt, bus_if.l_plntxt}, decrypt(64'd0, 32'd0));
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of the inverse rounds.
    issue(STD_KEY, STD_CU, STD_CL, STD_PT, t0);
    repeat (45) @(posedge clk);
    #2;
    dc0 = done_cnt;
    rst = 1'b1;
    #1;
    check("arst_busy", bus_if.busy, 0);
    check("arst_done", bus_if.done, 0);
    check("arst_u", bus_if.u_plntxt, 0);
    check("arst_l", bus_if.l_plntxt, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (70) @(posedge clk);
    #1;
    check("arst_no_done", done_cnt - dc0, 0);
    issue(STD_KEY, STD_CU, STD_CL, STD_PT, t0);
    wait_done("post_reset", t0, nb);
    check("post_reset_pt", {bus_if.u_plntxt, bus_if.l_plntxt}, STD_PT);
    @(posedge clk);
    #1;

    // Random roundtrip against the bench's encryption model.
    for (int n = 0; n < 200; n++) begin
      rk  = {$urandom(), $urandom()};
      rpt = $urandom();
      rct = encrypt(rk, rpt);
      issue(rk, rct[31:16], rct[15:0], rpt, t0);
      wait_done("rand", t0, nb);
      @(posedge clk);
      #1;
    end
    check("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/simon_decrypt_core.md
Name: simon_decrypt_core

Overview:
- Iterative Simon 32/64 decryption engine; the inverse direction of the team's existing per-round encryption datapath.
- Accepts a 64-bit key and a 32-bit ciphertext split into upper/lower 16-bit words.
- Expands the full 32-entry round-key schedule internally, then applies 32 inverse rounds in reverse key order.
- Sits beside the encryption pipeline in the full-cipher top level; start/busy/done handshake.

Parameters:
- ROUNDS, 32, number of Simon rounds (fixed for 32/64; not intended to be overridden)
- KEY_WORDS, 4, number of 16-bit key words (m)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset; asynchronous, active-high
- start  input  1  request; sampled only while busy=0
- key  input  64  master key; key[15:0]=k0, key[31:16]=k1, key[47:32]=k2, key[63:48]=k3
- u_cphrtxt  input  16  upper ciphertext word (x)
- l_cphrtxt  input  16  lower ciphertext word (y)
- busy  output  1  high from the cycle after start is accepted until completion
- done  output  1  one-cycle pulse when the plaintext outputs update
- u_plntxt  output  16  upper plaintext word, registered
- l_plntxt  output  16  lower plaintext word, registered

Behaviour:
- Reset (async, any time including mid-operation): FSM to IDLE; busy=0, done=0, u_plntxt=0, l_plntxt=0; the round counter and working x/y registers are cleared. Key register contents are don't-care.
- f(v) = (ROL1(v) & ROL8(v)) ^ ROL2(v).
- Inverse round with key k, given working (x,y): next x = y; next y = x ^ f(y) ^ k.
- Key schedule, for i = 0..27:
  - tmp = ROR3(k[i+3]) ^ k[i+1]
  - k[i+4] = 16'hFFFC ^ z0[i] ^ k[i] ^ tmp ^ ROR1(tmp)
  - z0 bit i is taken from 62'b11111010001001010110000111001101111101000100101011000011100110, with index 0 = MSB (leftmost).
  - Constant-XOR detail: c = 0xFFFC; z0[i] XORs into bit 0 only.
- FSM states: IDLE, EXPAND, DECRYPT.
- IDLE:
  - On an edge with start=1, capture k0..k3 from key into ks[0..3], and u_cphrtxt/l_cphrtxt into working x/y.
  - Set cnt=4, busy=1, go to EXPAND.
  - If start=0, hold; done=0.
- EXPAND:
  - Each edge writes ks[cnt] per the schedule and increments cnt.
  - After the edge writing ks[31] (28 edges), set cnt=31 and go to DECRYPT.
- DECRYPT:
  - Each edge applies the inverse round with ks[cnt] and decrements cnt.
  - On the edge applying ks[0] (32nd edge), load u_plntxt/l_plntxt with the resulting x/y, pulse done=1, set busy=0, go to IDLE.
- Latency: done is high in the cycle following the 60th rising edge after the start-sampling edge. Equivalently, 61 edges from start capture to done visible.
- Working x/y are internal. Outputs change only at completion and hold otherwise, including across a new operation until it completes.
- start while busy=1: ignored, no effect on the operation in flight. key and ciphertext inputs are not re-sampled while busy.
- start in the done cycle: accepted (FSM is IDLE). Back-to-back throughput is one result per 61 cycles.
- Arithmetic: all operations are 16-bit bitwise XOR/AND/rotations; no carries. cnt is 5 bits; no wrap occurs within the legal sequence.

Decomposition:
- Shared package simon_pkg holds:
  - SIMON_C = 16'hFFFC
  - SIMON_Z0 (62-bit constant)
  - ROUNDS, KEY_WORDS
  - function simon_f(v) (used by both the encryption round and this block)
  - ROL/ROR helpers
- One natural combinational sub-module: simon_key_step. Inputs are ki, ki1, ki3 and the z bit; output is k(i+4). It is reusable by any future encryption-side key expander.

Test Plan:
- Standard vector: key=64'h1918_1110_0908_0100, u_cphrtxt=16'hC69B, l_cphrtxt=16'hE9BB, start pulse -> done after 61 edges; u_plntxt=16'h6565, l_plntxt=16'h6877; busy high exactly 60 cycles.
- Key schedule probe: same key -> ks[4] equals the bench's Simon 32/64 reference model; ks[31] matches the model; all 32 entries are compared after EXPAND.
- Start while busy: second start with a different key/ciphertext at cycle 10 -> ignored; result remains 6565/6877 at the original done time; no second done.
- Back-to-back: start held high through the done cycle with new inputs (key=0, ct=0) -> second operation begins immediately; second done follows 61 cycles later with the value matching the bench model.
- Async reset mid-DECRYPT (cycle 45, between edges) -> outputs 0 and busy 0 immediately; no done. A subsequent standard-vector run gives 6565/6877.
- Randomised roundtrip: 200 random key/plaintext pairs encrypted by the bench model -> decrypted outputs equal the original plaintext.
